// File: rtl/clock_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared field widths, limits and mode encoding for the
//                timekeeping datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

   typedef enum logic [1:0] {
      MODE_CLOCK = 2'd0,
      MODE_LOAD  = 2'd1,
      MODE_ASET  = 2'd2
   } mode_e;

   // Load wins when both levels are high so an illegal FSM state can never
   // disturb the alarm setting.
   function automatic mode_e decode_mode(input logic load, input logic alarm);
      if (load) begin
         return MODE_LOAD;
      end
      if (alarm) begin
         return MODE_ASET;
      end
      return MODE_CLOCK;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clock_time_core_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : clock_time_core_if
//  Description : Mode levels, button pulses and display/ring outputs of the
//                timekeeping core. master = control side, slave = core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clock_time_core_if;
   import clock_pkg::*;

   logic              tick_1hz;
   logic              m_load;
   logic              m_alarm;
   logic              inc_sec;
   logic              inc_min;
   logic              inc_hour;
   logic              alarm_en;
   logic              alarm_stop;
   logic [SEC_W-1:0]  disp_sec;
   logic [MIN_W-1:0]  disp_min;
   logic [HOUR_W-1:0] disp_hour;
   logic              ring;

   modport master (
      output tick_1hz, m_load, m_alarm, inc_sec, inc_min, inc_hour,
             alarm_en, alarm_stop,
      input  disp_sec, disp_min, disp_hour, ring
   );

   modport slave (
      input  tick_1hz, m_load, m_alarm, inc_sec, inc_min, inc_hour,
             alarm_en, alarm_stop,
      output disp_sec, disp_min, disp_hour, ring
   );

endinterface
`default_nettype wire

// File: rtl/clock_time_core_mod_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mod_counter
//  Description : Modulo-(MAX_VAL+1) up counter with synchronous clear and a
//                carry that flags an increment taken at the maximum value.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
   parameter int WIDTH   = 6,
   parameter int MAX_VAL = 59
) (
   input  wire              m_clk,
   input  wire              m_reset_n,
   input  wire              inc,
   input  wire              clear,
   output logic [WIDTH-1:0] value,
   output logic             carry
);

   localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   // Next value: clear dominates, otherwise increment with wrap at C_MAX.
   always_comb begin
      value_d = value_q;
      if (clear) begin
         value_d = '0;
      end else if (inc) begin
         value_d = (value_q == C_MAX) ? '0 : value_q + WIDTH'(1);
      end
   end

   // Count register with asynchronous reset to zero.
   always_ff @(posedge m_clk or negedge m_reset_n) begin
      if (!m_reset_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign carry = inc & (value_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/clock_time_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : clock_time_core
//  Description : Running hh:mm:ss time, alarm hh:mm setting, alarm match and
//                ring timer, plus the display-select mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_time_core
   import clock_pkg::*;
#(
   parameter int RING_TICKS = 60,
   parameter int HOUR_MAX   = 23
) (
   input  wire               m_clk,
   input  wire               m_reset_n,
   clock_time_core_if.slave  bus
);

   localparam int             RC_W   = (RING_TICKS < 1) ? 1 : $clog2(RING_TICKS + 1);
   localparam logic [RC_W-1:0] C_RING = RC_W'(RING_TICKS);

   mode_e             w_mode;
   logic              w_load;
   logic              w_aset;
   logic              w_run;
   logic              w_tick_run;

   logic              w_sec_inc,  w_min_inc,  w_hour_inc;
   logic              w_sec_carry, w_min_carry, w_hour_carry;
   logic              w_amin_inc, w_ahour_inc;
   logic              w_amin_carry, w_ahour_carry;
   logic [SEC_W-1:0]  w_sec;
   logic [MIN_W-1:0]  w_min,  w_amin,  w_min_nxt;
   logic [HOUR_W-1:0] w_hour, w_ahour, w_hour_nxt;
   logic              w_match;

   logic [RC_W-1:0]   ring_cnt_q, ring_cnt_d;
   logic              ring_q, ring_d;

   assign w_mode     = decode_mode(bus.m_load, bus.m_alarm);
   assign w_load     = (w_mode == MODE_LOAD);
   assign w_aset     = (w_mode == MODE_ASET);
   assign w_run      = ~w_load;
   assign w_tick_run = w_run & bus.tick_1hz;

   // While running, increments ripple through the carries; while loading each
   // button steps only its own field (carries are not chained).
   assign w_sec_inc   = w_tick_run | (w_load & bus.inc_sec);
   assign w_min_inc   = w_run ? w_sec_carry : bus.inc_min;
   assign w_hour_inc  = w_run ? w_min_carry : bus.inc_hour;
   assign w_amin_inc  = w_aset & bus.inc_min;
   assign w_ahour_inc = w_aset & bus.inc_hour;

   mod_counter #(.WIDTH(SEC_W), .MAX_VAL(int'(SEC_MAX))) u_sec (
      .m_clk(m_clk), .m_reset_n(m_reset_n), .inc(w_sec_inc), .clear(1'b0),
      .value(w_sec), .carry(w_sec_carry)
   );

   mod_counter #(.WIDTH(MIN_W), .MAX_VAL(int'(MIN_MAX))) u_min (
      .m_clk(m_clk), .m_reset_n(m_reset_n), .inc(w_min_inc), .clear(1'b0),
      .value(w_min), .carry(w_min_carry)
   );

   mod_counter #(.WIDTH(HOUR_W), .MAX_VAL(HOUR_MAX)) u_hour (
      .m_clk(m_clk), .m_reset_n(m_reset_n), .inc(w_hour_inc), .clear(1'b0),
      .value(w_hour), .carry(w_hour_carry)
   );

   mod_counter #(.WIDTH(MIN_W), .MAX_VAL(int'(MIN_MAX))) u_amin (
      .m_clk(m_clk), .m_reset_n(m_reset_n), .inc(w_amin_inc), .clear(1'b0),
      .value(w_amin), .carry(w_amin_carry)
   );

   mod_counter #(.WIDTH(HOUR_W), .MAX_VAL(HOUR_MAX)) u_ahour (
      .m_clk(m_clk), .m_reset_n(m_reset_n), .inc(w_ahour_inc), .clear(1'b0),
      .value(w_ahour), .carry(w_ahour_carry)
   );

   // Time as it will be after this edge. A match only needs min/hour here:
   // alarm seconds are 0, so the seconds field must be rolling over from 59.
   // Compared against the alarm setting held before this edge.
   always_comb begin
      w_min_nxt  = w_min_carry  ? '0 : (w_min_inc  ? w_min  + MIN_W'(1)  : w_min);
      w_hour_nxt = w_hour_carry ? '0 : (w_hour_inc ? w_hour + HOUR_W'(1) : w_hour);
      w_match    = w_tick_run & bus.alarm_en & (w_sec == SEC_MAX) &
                   (w_min_nxt == w_amin) & (w_hour_nxt == w_ahour);
   end

   // Ring timer: stop/disarm beats a match, a match (re)loads, ticks count down.
   always_comb begin
      ring_cnt_d = ring_cnt_q;
      ring_d     = ring_q;
      if (bus.alarm_stop || !bus.alarm_en) begin
         ring_cnt_d = '0;
         ring_d     = 1'b0;
      end else if (w_match) begin
         ring_cnt_d = C_RING;
         ring_d     = (C_RING != '0);
      end else if (bus.tick_1hz && (ring_cnt_q != '0)) begin
         ring_cnt_d = ring_cnt_q - RC_W'(1);
         ring_d     = (ring_cnt_q != RC_W'(1));
      end
   end

   // Ring state registers; reset silences the alarm immediately.
   always_ff @(posedge m_clk or negedge m_reset_n) begin
      if (!m_reset_n) begin
         ring_cnt_q <= '0;
         ring_q     <= 1'b0;
      end else begin
         ring_cnt_q <= ring_cnt_d;
         ring_q     <= ring_d;
      end
   end

   // Display select follows the mode levels combinationally.
   always_comb begin
      bus.disp_sec  = w_sec;
      bus.disp_min  = w_min;
      bus.disp_hour = w_hour;
      if (w_aset) begin
         bus.disp_sec  = '0;
         bus.disp_min  = w_amin;
         bus.disp_hour = w_ahour;
      end
   end

   assign bus.ring = ring_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_clock_time_core
//  Description : Scoreboard bench for clock_time_core. The stimulus side keeps
//                a seconds-of-day reference model and queues the expected
//                display/ring after each edge; a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_time_core;
   import clock_pkg::*;

   localparam int RING = 60;
   localparam int HMAX = 23;
   localparam int DAY  = (HMAX + 1) * 3600;

   logic m_clk     = 1'b0;
   logic m_reset_n = 1'b0;

   clock_time_core_if bus();

   clock_time_core #(.RING_TICKS(RING), .HOUR_MAX(HMAX)) dut (
      .m_clk    (m_clk),
      .m_reset_n(m_reset_n),
      .bus      (bus)
   );

   always #5 m_clk = ~m_clk;

   typedef struct {
      int s;
      int m;
      int h;
      bit ring;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state: time as seconds of day, alarm fields, ticks left.
   int t_m   = 0;
   int am_m  = 0;
   int ah_m  = 0;
   int rem_m = 0;

   // Monitor: one expected entry per edge, compared at the following negedge.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge m_clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (bus.disp_hour !== 5'(e.h) || bus.disp_min !== 6'(e.m) ||
                bus.disp_sec !== 6'(e.s) || bus.ring !== e.ring) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t: got %0d:%0d:%0d ring=%0b, want %0d:%0d:%0d ring=%0b",
                        $time, bus.disp_hour, bus.disp_min, bus.disp_sec, bus.ring,
                        e.h, e.m, e.s, e.ring);
            end
         end
      end
   end

   // Drive one cycle of inputs, advance the model, queue the expectation and
   // return at negedge+1 after the edge that consumed the inputs.
   task automatic step(input bit tk, input bit ld, input bit al, input bit is,
                       input bit im, input bit ih, input bit en, input bit st);
      bit   aset    = al && !ld;
      bit   run     = !ld;
      int   nt      = t_m;
      int   alarm_t = ah_m * 3600 + am_m * 60;
      int   h, m, s;
      bit   match;
      exp_t e;
      bus.tick_1hz   = tk;
      bus.m_load     = ld;
      bus.m_alarm    = al;
      bus.inc_sec    = is;
      bus.inc_min    = im;
      bus.inc_hour   = ih;
      bus.alarm_en   = en;
      bus.alarm_stop = st;
      if (run && tk) nt = (t_m + 1) % DAY;
      if (ld) begin
         h = t_m / 3600; m = (t_m / 60) % 60; s = t_m % 60;
         if (is) s = (s + 1) % 60;
         if (im) m = (m + 1) % 60;
         if (ih) h = (h + 1) % (HMAX + 1);
         nt = h * 3600 + m * 60 + s;
      end
      match = run && tk && en && (nt == alarm_t);
      if (aset && im) am_m = (am_m + 1) % 60;
      if (aset && ih) ah_m = (ah_m + 1) % (HMAX + 1);
      t_m = nt;
      if (st || !en)       rem_m = 0;
      else if (match)      rem_m = RING;
      else if (tk && rem_m > 0) rem_m = rem_m - 1;
      e.ring = (rem_m > 0);
      if (aset) begin
         e.h = ah_m; e.m = am_m; e.s = 0;
      end else begin
         e.h = t_m / 3600; e.m = (t_m / 60) % 60; e.s = t_m % 60;
      end
      q.push_back(e);
      @(negedge m_clk);
      #1;
   endtask

   task automatic check_const(input string name, input int h, input int m,
                              input int s, input bit r);
      n_checks++;
      if (bus.disp_hour !== 5'(h) || bus.disp_min !== 6'(m) ||
          bus.disp_sec !== 6'(s) || bus.ring !== r) begin
         n_fail++;
         $display("FAIL %s: got %0d:%0d:%0d ring=%0b, want %0d:%0d:%0d ring=%0b",
                  name, bus.disp_hour, bus.disp_min, bus.disp_sec, bus.ring, h, m, s, r);
      end
   endtask

   task automatic set_time(input int h, input int m, input int s, input bit en);
      for (int k = 0; k < 80; k++) begin
         if (t_m / 3600 == h && (t_m / 60) % 60 == m && t_m % 60 == s) break;
         step(0, 1, 0, (t_m % 60) != s, ((t_m / 60) % 60) != m, (t_m / 3600) != h, en, 0);
      end
   endtask

   task automatic set_alarm(input int h, input int m, input bit en);
      for (int k = 0; k < 80; k++) begin
         if (ah_m == h && am_m == m) break;
         step(0, 0, 1, 0, am_m != m, ah_m != h, en, 0);
      end
   endtask

   initial begin : stim
      bus.tick_1hz = 0; bus.m_load = 0; bus.m_alarm = 0; bus.inc_sec = 0;
      bus.inc_min = 0; bus.inc_hour = 0; bus.alarm_en = 0; bus.alarm_stop = 0;
      #2;
      check_const("reset_state", 0, 0, 0, 0);
      @(negedge m_clk); @(negedge m_clk); #1;
      m_reset_n = 1'b1;

      // Carry chain through every field in one edge.
      set_time(23, 59, 58, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check_const("carry_59", 23, 59, 59, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check_const("carry_wrap", 0, 0, 0, 0);

      // Ticks ignored in LOAD, simultaneous buttons, seconds wrap without carry.
      set_time(10, 20, 30, 0);
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
      check_const("load_frozen", 10, 20, 30, 0);
      step(0, 1, 0, 1, 1, 1, 0, 0);
      check_const("load_all_inc", 11, 21, 31, 0);
      set_time(11, 21, 59, 0);
      step(0, 1, 0, 1, 0, 0, 0, 0);
      check_const("load_sec_wrap", 11, 21, 0, 0);

      // Alarm setting while time keeps running; display mux per mode.
      for (int i = 0; i < 30; i++) step(1, 0, 1, 1, 1, (i < 7), 0, 0);
      check_const("aset_disp", 7, 30, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check_const("clock_disp", 11, 21, 30, 0);

      // Ring lasts exactly RING ticks; idle cycles between ticks do not count.
      set_time(7, 29, 59, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      check_const("ring_on", 7, 30, 0, 1);
      for (int i = 0; i < RING - 1; i++) begin
         step(1, 0, 0, 0, 0, 0, 1, 0);
         step(0, 0, 0, 0, 0, 0, 1, 0);
      end
      check_const("ring_last", 7, 30, 59, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      check_const("ring_off", 7, 31, 0, 0);

      // Stop with a coincident tick, stop at the match, disarmed match.
      set_time(7, 29, 59, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 1, 1);
      check_const("stop_with_tick", 7, 30, 4, 0);
      set_time(7, 29, 59, 1);
      step(1, 0, 0, 0, 0, 0, 1, 1);
      check_const("stop_at_match", 7, 30, 0, 0);
      set_time(7, 29, 59, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check_const("en_off_match", 7, 30, 0, 0);

      // Randomized phase, started just before the alarm time.
      set_time(7, 25, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         int unsigned md = $urandom % 8;
         step(($urandom % 3) == 0, md >= 4 && md != 6, md >= 6,
              ($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
              ($urandom % 16) != 0, ($urandom % 40) == 0);
      end

      // Asynchronous reset in the middle of a ring.
      set_alarm(7, 30, 1);
      set_time(7, 29, 59, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      check_const("pre_reset_ring", 7, 30, 0, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0);
      #2;
      m_reset_n = 1'b0;
      #1;
      check_const("async_reset", 0, 0, 0, 0);
      t_m = 0; am_m = 0; ah_m = 0; rem_m = 0;
      @(negedge m_clk); @(negedge m_clk); #1;
      m_reset_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0);

      @(negedge m_clk); #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: %0d entries left, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clock_time_core.md
# clock_time_core

Timekeeping datapath that sits directly downstream of the mode FSM. It consumes the FSM's `m_load` and `m_alarm` levels, a 1 Hz enable and button pulses. It maintains the running hh:mm:ss time, the alarm hh:mm setting and the alarm ring output. It also drives the display-select fields.

## Interface
Parameters:
- `RING_TICKS`, default 60: number of 1 Hz ticks the alarm rings before self-clearing.
- `HOUR_MAX`, default 23: last hour value before wrapping to 0.

Ports:
- `m_clk`, input, 1: system clock; all state changes on its rising edge.
- `m_reset_n`, input, 1: asynchronous, active-low reset.
- `tick_1hz`, input, 1: one-`m_clk`-cycle enable, once per second.
- `m_load`, input, 1: load-time mode level from the FSM.
- `m_alarm`, input, 1: alarm-set mode level from the FSM.
- `inc_sec`, `inc_min`, `inc_hour`, input, 1 each: single-cycle button pulses, already debounced.
- `alarm_en`, input, 1: alarm armed (switch level).
- `alarm_stop`, input, 1: single-cycle pulse that silences the ring.
- `disp_sec`, output, 6: seconds shown on the display.
- `disp_min`, output, 6: minutes shown on the display.
- `disp_hour`, output, 5: hours shown on the display.
- `ring`, output, 1: alarm sounding.

## Operation
- Modes decoded from the FSM levels:
  - CLOCK: `m_load`=0 and `m_alarm`=0.
  - LOAD: `m_load`=1. Also taken when both levels are 1, which is illegal; alarm registers are then untouched.
  - ASET: `m_alarm`=1 and `m_load`=0.
- CLOCK:
  - On `tick_1hz`, sec increments. At 59 it wraps to 0 and carries into min.
  - min wraps 59 to 0 and carries into hour; hour wraps `HOUR_MAX` to 0.
  - `inc_*` pulses are ignored.
- LOAD:
  - `tick_1hz` is ignored; time is frozen.
  - Each `inc_*` increments its own time field modulo that field's range, with no carry.
  - Simultaneous `inc_*` pulses all apply in the same cycle.
- ASET:
  - Time keeps running on `tick_1hz`.
  - `inc_min` and `inc_hour` modify the alarm min and alarm hour registers, modulo range, no carry.
  - `inc_sec` is ignored; alarm seconds are fixed at 0.
  - A tick and an inc in the same cycle both apply, since they target different registers.
- Alarm match:
  - The check runs on the cycle where a tick (CLOCK or ASET) produces time == alarm_hour:alarm_min:00 while `alarm_en`=1.
  - On a match, `ring` is set and the ring counter is loaded with `RING_TICKS`.
  - Setting time in LOAD never triggers a match.
- Ring:
  - Counter decrements on each `tick_1hz`; `ring` clears when it reaches 0.
  - `alarm_stop`=1 or `alarm_en`=0 clears `ring` and the counter on the next edge. These take priority over a coincident match.
  - A match while already ringing reloads the counter.
- Display mux (combinational):
  - ASET: alarm_hour:alarm_min:00.
  - Otherwise: time.
- Reset values, asynchronous:
  - time 00:00:00, alarm 00:00.
  - ring counter 0, `ring`=0, so `disp_*`=0.
  - Reset mid-operation aborts any ring immediately.

## Timing
- All registers are updated on the `m_clk` rising edge, one cycle after the qualifying input is sampled high.
- `disp_*` follow a mode change combinationally, in the same cycle.
- `ring` asserts on the edge that registers the matching time, i.e. the same edge on which `disp_*` shows the match.
- Inputs must be synchronous to `m_clk`; `tick_1hz` and the button pulses are exactly one cycle wide.
- Ring duration is exactly `RING_TICKS` ticks from the match, when not stopped.

## Structure
- Shared package `clock_pkg`:
  - Field widths: SEC_W=6, MIN_W=6, HOUR_W=5.
  - Limits: SEC_MAX=59, MIN_MAX=59.
  - Mode encoding: CLOCK, LOAD, ASET.
- Sub-module `mod_counter`, parameterized by width and max value:
  - Inputs: inc and clear.
  - Outputs: value and carry (inc at max).
  - Instantiated 3× for time and 2× for alarm.
- Mode decode, carry chaining, match and ring logic live in the top level.

## Test plan
- Carry chain: reset, CLOCK mode, preload 23:59:58 via LOAD, then 2 ticks. Required: 23:59:59, then 00:00:00 with all fields wrapping in one edge.
- LOAD freeze: set time 10:20:30, enter LOAD, apply 5 ticks plus one each of `inc_sec`/`inc_min`/`inc_hour` in the same cycle. Required: 11:21:31, unchanged by the ticks; `inc_sec` at 59 wraps to 0 with min unchanged.
- Alarm set and display: in ASET, apply 7 `inc_hour` and 30 `inc_min`. Required: `disp_*`=07:30:00 while time advances. On return to CLOCK, `disp_*` shows the running time.
- Ring: alarm 07:30, `alarm_en`=1, time 07:29:59, tick. Required: `ring`=1 at 07:30:00, and `ring`=0 exactly 60 ticks later.
- Stop priority: ringing, then `alarm_stop` coincident with a tick. Required: `ring`=0 next edge. Also, `alarm_en`=0 at the match cycle gives no ring.
- Async reset: assert `m_reset_n`=0 mid-ring between clock edges. Required: `ring`=0 and `disp_*`=00:00:00 immediately, with no clock edge.
